// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B, LSB first, one bit per clock.
// A single full-subtractor cell plus a registered borrow. A start/done handshake
// launches one operation at a time.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             br_next_c;
  logic             load_c;
  logic             shift_c;
  logic             last_c;

  // Full-subtractor cell on the current LSBs and the stored borrow
  always_comb begin
    d_c       = sa[0] ^ sb[0] ^ br;
    br_next_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Next-state and datapath control
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    shift_c = 1'b0;
    last_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        shift_c = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        // Accepting here gives back-to-back operation with no IDLE gap
        if (start) begin
          load_c  = 1'b1;
          state_n = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered status flags tracking the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == BUSY);
      done  <= (state_n == DONE);
    end
  end

  // Operand/result shift registers, borrow and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (load_c) begin
      sa  <= a;
      sb  <= b;
      sr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (shift_c) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= {d_c, sr[WIDTH-1:1]};
      br  <= br_next_c;
      cnt <= cnt + CW'(1);
    end
  end

  // Result registers hold until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_c) begin
      diff <= {d_c, sr[WIDTH-1:1]};
      bout <= br_next_c;
    end
  end

endmodule
